pingpong_bram_ctrl: RTL
=======================

Name: pingpong_bram_ctrl

Overview:
Single-clock sequencer for the two-bank BRAM line buffer.
- Write side: accepts 8-bit pixels from the external-memory source and fills one bank through the bank's 8-bit write port.
- Read side: drains the other bank through its 32-bit read port, one byte lane per beat, by driving the byte-select mux.
- Banks swap when the write bank is full and the read bank is drained. `complete` pulses after the programmed number of lines has been read out.

Parameters:
- LINE_BYTES, 2048, bytes per line (one bank fill); must be a multiple of 4.
- WR_AW, 11, write address width (byte address, 8-bit port).
- RD_AW, 9, read address width (word address, 32-bit port); RD_AW = WR_AW-2.
- LINES_W, 16, width of the line-count input.

Ports:
- CLK  in  1  sole clock.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_lines  in  LINES_W  lines to process; latched on start.
- src_valid  in  1  source byte available.
- src_ready  out  1  controller accepts a source byte this cycle.
- ena  out  1  write-port enable, common to both banks.
- wea  out  2  per-bank write strobe; bit0 = bank0, bit1 = bank1.
- addra  out  WR_AW  write byte address.
- enb  out  1  read-port enable (fetch strobe).
- addrb  out  RD_AW  read word address.
- rd_bank  out  1  bank whose output currently feeds the lane mux.
- sel  out  2  byte lane, 0..3.
- out_valid  out  1  selected byte is valid.
- out_ready  in  1  downstream accepts the byte.
- busy  out  1  run in progress.
- complete  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; all counters = 0; wbank=0.
  - All outputs 0, including wea, enb, addra, addrb, sel, rd_bank, src_ready, out_valid, busy and complete.
  - Reset asserted mid-run aborts the run immediately; no complete pulse.
- States: IDLE, FILL, STREAM, DRAIN, DONE.
  - IDLE: start=1 and num_lines=0 -> DONE. start=1 and num_lines>0 -> FILL, with num_lines latched. start is ignored outside IDLE.
  - FILL: writes only. When the last byte is written: if lines_written==num_lines -> DRAIN, else -> STREAM. In both cases the filled bank becomes the read bank and wbank toggles.
  - STREAM: writes and reads run concurrently. Swap occurs when the write bank is full AND the read bank is drained (the last lane 3 of the last word has been accepted). The swap happens in the later of the two cycles.
    - At swap: if lines_written==num_lines -> DRAIN, else remain in STREAM.
    - A full write bank deasserts src_ready until the swap. A drained read bank holds out_valid=0 until the swap.
  - DRAIN: reads only; src_ready=0. When the last byte of line num_lines is accepted -> DONE.
  - DONE: complete=1 for one cycle, busy=0 -> IDLE.
- busy=1 in FILL, STREAM and DRAIN.
- Write path:
  - src_ready=1 when in FILL or STREAM, the write bank is not full, and lines_written < num_lines.
  - On src_valid&src_ready, in the same cycle: ena=1, wea[wbank]=1, addra=wcnt. wcnt increments after the write.
  - The write bank is full when the write at wcnt==LINE_BYTES-1 occurs; wcnt wraps to 0 and lines_written increments.
- Read path, with BRAM read latency of 1:
  - Fetch: enb=1 with addrb=rword. The word is valid on doutb the next cycle and held while enb=0.
  - On the cycle after a fetch: out_valid=1, sel=0.
  - Each accepted beat (out_valid&out_ready) increments sel.
  - Accepting lane 3 issues the next fetch in the same cycle when words remain. The next word then starts at sel=0 with no bubble, giving a sustained rate of 1 byte/cycle.
  - After the last word (rword==LINE_BYTES/4-1), acceptance of lane 3 drains the bank: lines_read increments and rword wraps to 0.
  - out_ready=0 holds sel and out_valid; no fetch is issued.
- Simultaneous write-full and read-drain in the same cycle: swap in that cycle. No byte is lost or duplicated.
- Counter widths:
  - wcnt: WR_AW bits.
  - rword: RD_AW bits.
  - lines_written, lines_read: LINES_W bits.
  - Comparisons are unsigned.

Decomposition:
- Shared package pingpong_pkg holds:
  - state enum (IDLE/FILL/STREAM/DRAIN/DONE)
  - LINE_BYTES, WR_AW, RD_AW defaults
  - BRAM_RD_LAT=1
- One natural sub-module: rd_lane_seq, the fetch/lane sequencer. It owns rword, sel, out_valid, enb and the drained flag. It takes go and a bank-swap pulse.

Test Plan:
(All scenarios use LINE_BYTES=8 in simulation.)
1. Reset then start with num_lines=0: complete pulses exactly 1 cycle later. No wea or enb ever asserted.
2. num_lines=1, src_valid and out_ready held at 1:
   - 8 writes to bank0 at addra 0..7 on consecutive cycles.
   - DRAIN then reads words 0,1 with sel 0,1,2,3,0,1,2,3; output bytes match input order.
   - complete pulses 1 cycle after the last beat.
3. num_lines=3, continuous flow:
   - Banks alternate 0,1,0 for writes.
   - rd_bank follows one line behind.
   - No out_valid gap within a line; total 24 bytes out, in order.
4. num_lines=2, out_ready=0 during line 0 read:
   - Bank1 fills, then src_ready drops to 0 and stays 0 until out_ready resumes and bank0 drains.
   - Swap occurs on the drain cycle.
5. Assert RESET mid-STREAM (after 5 bytes of line 1): all outputs 0 asynchronously, no complete pulse. A new start with num_lines=1 then runs cleanly from bank0.
6. start pulsed again while busy: ignored. num_lines is not re-latched and the run completes with the original count.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared types and default geometry for the two-bank BRAM line-buffer sequencer.
package pingpong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DEF_LINE_BYTES = 2048;
    localparam int unsigned DEF_WR_AW      = 11;
    localparam int unsigned DEF_RD_AW      = 9;
    localparam int unsigned DEF_LINES_W    = 16;
    localparam int unsigned BRAM_RD_LAT    = 1;

endpackage

// File: rtl/pingpong_bram_ctrl_rd_lane_seq.sv
// Read-side fetch / byte-lane sequencer: walks the 32-bit words of the read bank
// and steps the lane select one accepted byte at a time.
module rd_lane_seq
    import pingpong_pkg::*;
#(
    parameter int unsigned WORDS = DEF_LINE_BYTES / 4,
    parameter int unsigned RD_AW = DEF_RD_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             load,
    input  logic             out_ready,
    output logic             fetch_c,
    output logic [RD_AW-1:0] addrb,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic             drained,
    output logic             drain_c
);

    logic [RD_AW-1:0] rword;
    logic             cur_last;
    logic             fetch_pend;
    logic             lane3;

    // Lane 3 acceptance either chains the next fetch (no bubble) or drains the bank.
    assign lane3   = out_valid && out_ready && (sel == 2'd3);
    assign fetch_c = go && (fetch_pend || (lane3 && !cur_last));
    assign drain_c = go && lane3 && cur_last;
    assign addrb   = rword;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rword      <= '0;
            cur_last   <= 1'b0;
            fetch_pend <= 1'b0;
            sel        <= 2'd0;
            out_valid  <= 1'b0;
            drained    <= 1'b1;
        end else if (!go) begin
            rword      <= '0;
            cur_last   <= 1'b0;
            fetch_pend <= 1'b0;
            sel        <= 2'd0;
            out_valid  <= 1'b0;
            drained    <= 1'b1;
        end else begin
            if (fetch_c) begin
                rword      <= (rword == RD_AW'(WORDS - 1)) ? '0 : rword + RD_AW'(1);
                cur_last   <= (rword == RD_AW'(WORDS - 1));
                fetch_pend <= 1'b0;
                sel        <= 2'd0;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                sel <= sel + 2'd1;
                if (drain_c) begin
                    out_valid <= 1'b0;
                end
            end
            if (drain_c) begin
                drained <= 1'b1;
            end
            // A freshly handed-over bank wins over a same-cycle drain of the old one.
            if (load) begin
                drained    <= 1'b0;
                fetch_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pingpong_bram_ctrl.sv
// Ping-pong line-buffer sequencer: fills one BRAM bank byte-wise while the other
// bank is drained word-wise through a byte-lane mux; banks swap once both sides finish.
module pingpong_bram_ctrl
    import pingpong_pkg::*;
#(
    parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
    parameter int unsigned WR_AW      = DEF_WR_AW,
    parameter int unsigned RD_AW      = DEF_RD_AW,
    parameter int unsigned LINES_W    = DEF_LINES_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [LINES_W-1:0] num_lines,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               ena,
    output logic [1:0]         wea,
    output logic [WR_AW-1:0]   addra,
    output logic               enb,
    output logic [RD_AW-1:0]   addrb,
    output logic               rd_bank,
    output logic [1:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               complete
);

    state_t             state;
    state_t             state_nxt;
    logic [WR_AW-1:0]   wcnt;
    logic [LINES_W-1:0] nlines;
    logic [LINES_W-1:0] lines_written;
    logic [LINES_W-1:0] lines_read;
    logic [LINES_W-1:0] lw_next;
    logic [LINES_W-1:0] lr_next;
    logic               wbank;
    logic               wfull;
    logic               wlast;
    logic               swap_c;
    logic               rd_drained;
    logic               rd_drain_c;

    assign busy     = (state == FILL) || (state == STREAM) || (state == DRAIN);
    assign complete = (state == DONE);
    assign addra    = wcnt;

    rd_lane_seq #(
        .WORDS (LINE_BYTES / 4),
        .RD_AW (RD_AW)
    ) u_rd_lane_seq (
        .clk       (CLK),
        .rst_n     (RESET),
        .go        (busy),
        .load      (swap_c),
        .out_ready (out_ready),
        .fetch_c   (enb),
        .addrb     (addrb),
        .sel       (sel),
        .out_valid (out_valid),
        .drained   (rd_drained),
        .drain_c   (rd_drain_c)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, write strobes and the bank-swap decision.
    always_comb begin
        state_nxt = state;
        swap_c    = 1'b0;
        src_ready = ((state == FILL) || (state == STREAM)) && !wfull
                    && (lines_written < nlines);
        ena       = src_valid && src_ready;
        wea       = {ena && wbank, ena && !wbank};
        wlast     = ena && (wcnt == WR_AW'(LINE_BYTES - 1));
        lw_next   = lines_written + LINES_W'(wlast);
        lr_next   = lines_read + LINES_W'(rd_drain_c);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_lines == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (wlast) begin
                    swap_c    = 1'b1;
                    state_nxt = (lw_next == nlines) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if ((wfull || wlast) && (rd_drained || rd_drain_c)) begin
                    swap_c    = 1'b1;
                    state_nxt = (lw_next == nlines) ? DRAIN : STREAM;
                end
            end
            DRAIN: begin
                if (rd_drain_c && (lr_next == nlines)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            nlines        <= '0;
            wcnt          <= '0;
            lines_written <= '0;
            lines_read    <= '0;
            wbank         <= 1'b0;
            wfull         <= 1'b0;
            rd_bank       <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                nlines        <= num_lines;
                wcnt          <= '0;
                lines_written <= '0;
                lines_read    <= '0;
                wbank         <= 1'b0;
                wfull         <= 1'b0;
                rd_bank       <= 1'b0;
            end
        end else begin
            if (ena) begin
                wcnt <= wlast ? '0 : wcnt + WR_AW'(1);
            end
            lines_written <= lw_next;
            lines_read    <= lr_next;
            if (swap_c) begin
                wbank   <= !wbank;
                rd_bank <= wbank;
                wfull   <= 1'b0;
            end else if (wlast) begin
                wfull <= 1'b1;
            end
        end
    end

endmodule
